engine_result_collector: RTL and testbench

//  Downstream of the pixel distributor. Waits until all NUM_ENGINES engines finish their current pixel batch.

---
 rtl/pixel_pkg.sv | 17 +
 rtl/raster_counter.sv | 32 +++
 rtl/engine_result_collector.sv | 106 ++++++++++
 tb/tb_engine_result_collector.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel-pipeline constants and the result collector state encoding.
package pixel_pkg;

  localparam int unsigned PIXEL_DATA_WIDTH = 10;
  localparam int unsigned SCREEN_WIDTH     = 640;
  localparam int unsigned SCREEN_HEIGHT    = 480;
  localparam int unsigned NUM_ENGINES      = 12;
  localparam int unsigned ITER_WIDTH       = 8;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2,
    GUARD  = 2'd3
  } collector_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter: advances one pixel per enable, wraps at line and frame end.
module raster_counter #(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] X_LAST = WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [WIDTH-1:0] Y_LAST = WIDTH'(SCREEN_HEIGHT - 1);

  // Position update: compare-and-wrap only, no modulo hardware
  always_ff @(posedge clk) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + WIDTH'(1);
      end else begin
        x <= x + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/engine_result_collector.sv
// Collects one batch of engine results and streams them out in engine order
// with per-pixel start-of-frame / end-of-line markers.
module engine_result_collector #(
  parameter int unsigned PIXEL_DATA_WIDTH = pixel_pkg::PIXEL_DATA_WIDTH,
  parameter int unsigned SCREEN_WIDTH     = pixel_pkg::SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT    = pixel_pkg::SCREEN_HEIGHT,
  parameter int unsigned NUM_ENGINES      = pixel_pkg::NUM_ENGINES,
  parameter int unsigned ITER_WIDTH       = pixel_pkg::ITER_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENGINES-1:0] eng_done,
  input  logic [ITER_WIDTH-1:0]  eng_iter [NUM_ENGINES-1:0],
  output logic                   fin_flag,
  output logic [ITER_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eol
);

  import pixel_pkg::*;

  localparam int unsigned K_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_ENGINES - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);

  collector_state_t            state;
  logic [K_W-1:0]              k;
  logic [ITER_WIDTH-1:0]       capture_buf [NUM_ENGINES];
  logic                        beat_accept;
  logic [PIXEL_DATA_WIDTH-1:0] x;
  logic [PIXEL_DATA_WIDTH-1:0] y;

  // out_valid is only ever set while streaming, so this is the beat transfer
  assign beat_accept = out_valid && out_ready;

  // Markers follow the registered raster position and only qualify live beats
  assign out_sof = out_valid && (x == '0) && (y == '0);
  assign out_eol = out_valid && (x == X_LAST);

  // Raster position of the beat currently presented on the stream
  raster_counter #(
    .WIDTH        (PIXEL_DATA_WIDTH),
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .advance(beat_accept),
    .x      (x),
    .y      (y)
  );

  // Batch FSM: capture on all-done, stream N beats, pulse fin_flag, one guard cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= WAIT;
      k         <= '0;
      fin_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < int'(NUM_ENGINES); i++) begin
        capture_buf[i] <= '0;
      end
    end else begin
      fin_flag <= 1'b0;
      case (state)
        WAIT: begin
          if (&eng_done) begin
            for (int i = 0; i < int'(NUM_ENGINES); i++) begin
              capture_buf[i] <= eng_iter[i];
            end
            k         <= '0;
            out_data  <= eng_iter[0];
            out_valid <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (k == K_LAST) begin
              out_valid <= 1'b0;
              fin_flag  <= 1'b1;
              state     <= FIN;
            end else begin
              k        <= k + K_W'(1);
              out_data <= capture_buf[k + K_W'(1)];
            end
          end
        end
        FIN: begin
          state <= GUARD;
        end
        GUARD: begin
          // Engines are still dropping eng_done here; never recapture
          state <= WAIT;
        end
        default: begin
          state <= WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_engine_result_collector.sv
// Bench for engine_result_collector: vector table for idle/reset behaviour,
// scoreboard-checked batches, and hand-written multi-cycle corner cases.
module tb_engine_result_collector;

  localparam int unsigned N  = 12;
  localparam int unsigned SW = 640;
  localparam int unsigned SH = 480;

  logic         clk;
  logic         reset;
  logic [N-1:0] eng_done;
  logic [7:0]   eng_iter [N-1:0];
  logic         fin_flag;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sof;
  logic         out_eol;
  logic         rc_adv;
  logic [9:0]   rc_x;
  logic [9:0]   rc_y;

  engine_result_collector dut (
    .clk      (clk),
    .reset    (reset),
    .eng_done (eng_done),
    .eng_iter (eng_iter),
    .fin_flag (fin_flag),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof  (out_sof),
    .out_eol  (out_eol)
  );

  // Small raster so a full frame wrap is reachable in a few cycles
  raster_counter #(.WIDTH(10), .SCREEN_WIDTH(5), .SCREEN_HEIGHT(3)) rc (
    .clk    (clk),
    .reset  (reset),
    .advance(rc_adv),
    .x      (rc_x),
    .y      (rc_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eol;
  } beat_t;

  typedef struct {
    logic         rst;
    logic [N-1:0] done;
    logic         rdy;
    int           cycles;
    logic         exp_valid;
    logic         exp_fin;
    logic [7:0]   exp_data;
  } vec_t;

  beat_t       exp_q [$];
  vec_t        vecs [4];
  int          checks  = 0;
  int          errors  = 0;
  int          fin_cnt = 0;
  int          eol_cnt = 0;
  int          sof_cnt = 0;
  int unsigned mx = 0;
  int unsigned my = 0;
  logic        hold_v = 1'b0;
  logic [7:0]  hold_d;
  logic        hold_s;
  logic        hold_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stream monitor: scoreboard pop on transfers, stall stability, fin accounting
  always @(negedge clk) begin
    beat_t e;
    if (reset !== 1'b1) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(hold_d));
        chk("stall_sof", int'(out_sof), int'(hold_s));
        chk("stall_eol", int'(out_eol), int'(hold_e));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", int'(out_data), int'(e.data));
          chk("beat_sof", int'(out_sof), int'(e.sof));
          chk("beat_eol", int'(out_eol), int'(e.eol));
        end
        if (out_sof === 1'b1) sof_cnt++;
        if (out_eol === 1'b1) eol_cnt++;
      end
      if (fin_flag === 1'b1) begin
        fin_cnt++;
        chk("fin_while_valid", int'(out_valid), 0);
      end
      hold_v = (out_valid === 1'b1) && (out_ready !== 1'b1);
      hold_d = out_data;
      hold_s = out_sof;
      hold_e = out_eol;
    end
  end

  // Load a batch onto eng_iter and queue its expected beats from the raster model
  task automatic push_batch(input logic [7:0] base);
    beat_t e;
    for (int i = 0; i < int'(N); i++) begin
      eng_iter[i] = base + 8'(i);
      e.data = base + 8'(i);
      e.sof  = (mx == 0) && (my == 0);
      e.eol  = (mx == SW - 1);
      exp_q.push_back(e);
      if (mx == SW - 1) begin
        mx = 0;
        my = (my == SH - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
  endtask

  // Full batch: mode 0 ready=1, mode 1 ready alternating from 1, mode 2 random
  task automatic run_batch(input logic [7:0] base, input int mode,
                           input int exp_wait, input int exp_len);
    int n;
    int cyc;
    bit got_fin;
    int fin0;
    push_batch(base);
    fin0 = fin_cnt;
    eng_done = '1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (out_valid !== 1'b1 && n < 8);
    chk("capture_valid", int'(out_valid), 1);
    if (exp_wait > 0) chk("capture_latency", n, exp_wait);
    eng_done = '0;
    cyc = 0;
    got_fin = 1'b0;
    while (!got_fin && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      cyc++;
      if (fin_flag === 1'b1) got_fin = 1'b1;
    end
    chk("fin_seen", int'(got_fin), 1);
    if (exp_len > 0) chk("batch_cycles", cyc, exp_len);
    chk("queue_drained", exp_q.size(), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("fin_one_cycle", int'(fin_flag), 0);
    chk("guard_idle", int'(out_valid), 0);
    chk("fin_count", fin_cnt - fin0, 1);
  endtask

  initial begin
    int n;
    int f0;
    int s0;
    int e0;
    int mrx;
    int mry;

    reset     = 1'b0;
    eng_done  = '1;
    out_ready = 1'b1;
    rc_adv    = 1'b0;
    for (int i = 0; i < int'(N); i++) eng_iter[i] = 8'hA5 + 8'(i);

    // Reset with all done, release idle, long partial-done windows
    vecs[0] = '{rst: 1'b0, done: 12'hFFF, rdy: 1'b1, cycles: 3,   exp_valid: 1'b0, exp_fin: 1'b0, exp_data: 8'd0};
    vecs[1] = '{rst: 1'b1, done: 12'h000, rdy: 1'b1, cycles: 2,   exp_valid: 1'b0, exp_fin: 1'b0, exp_data: 8'd0};
    vecs[2] = '{rst: 1'b1, done: 12'h7FF, rdy: 1'b1, cycles: 100, exp_valid: 1'b0, exp_fin: 1'b0, exp_data: 8'd0};
    vecs[3] = '{rst: 1'b1, done: 12'hFFE, rdy: 1'b0, cycles: 10,  exp_valid: 1'b0, exp_fin: 1'b0, exp_data: 8'd0};

    for (int v = 0; v < 4; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) begin
        reset     = vecs[v].rst;
        eng_done  = vecs[v].done;
        out_ready = vecs[v].rdy;
        @(posedge clk); #1;
        chk($sformatf("vec%0d_valid", v), int'(out_valid), int'(vecs[v].exp_valid));
        chk($sformatf("vec%0d_fin", v), int'(fin_flag), int'(vecs[v].exp_fin));
        chk($sformatf("vec%0d_data", v), int'(out_data), int'(vecs[v].exp_data));
      end
    end
    chk("idle_no_fin", fin_cnt, 0);

    // Standalone raster counter through a full small-frame wrap
    mrx = 0;
    mry = 0;
    for (int i = 0; i < 20; i++) begin
      rc_adv = (i % 4 != 3);
      @(posedge clk); #1;
      if (rc_adv) begin
        if (mrx == 4) begin
          mrx = 0;
          mry = (mry == 2) ? 0 : mry + 1;
        end else begin
          mrx++;
        end
      end
      chk("rc_x", int'(rc_x), mrx);
      chk("rc_y", int'(rc_y), mry);
    end
    rc_adv = 1'b0;

    // Raising the last engine from idle: data 1..12, sof once, fin at t+13
    s0 = sof_cnt;
    run_batch(8'd1, 0, 1, 12);
    chk("first_batch_sof", sof_cnt - s0, 1);

    // Alternating ready, back-to-back after guard
    run_batch(8'd1, 1, 2, 23);

    // Random backpressure, including 8-bit data wrap
    run_batch(8'd250, 2, 2, 0);
    run_batch(8'd40, 2, 2, 0);
    run_batch(8'd77, 2, 2, 0);

    // Reset while beat 6 is on the bus aborts without fin_flag
    f0 = fin_cnt;
    push_batch(8'd100);
    eng_done  = '1;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (out_valid !== 1'b1 && n < 8);
    chk("abort_capture", int'(out_valid), 1);
    eng_done = '0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("abort_beat6", int'(out_data), 105);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_fin", int'(fin_flag), 0);
    chk("abort_sof", int'(out_sof), 0);
    chk("abort_eol", int'(out_eol), 0);
    chk("abort_data", int'(out_data), 0);
    exp_q.delete();
    mx = 0;
    my = 0;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_no_fin", fin_cnt - f0, 0);
    chk("abort_idle", int'(out_valid), 0);

    // 54 batches from frame start: one eol (pixel 639, batch 53 beat 3)
    e0 = eol_cnt;
    s0 = sof_cnt;
    for (int b = 0; b < 54; b++) begin
      run_batch(8'(b * 3), 0, (b == 0) ? 1 : 2, 12);
    end
    chk("eol_in_54_batches", eol_cnt - e0, 1);
    chk("sof_in_54_batches", sof_cnt - s0, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
